// File: rtl/phy_len_div_calc_pkg.sv
// Shared constants, N_DBPS base tables and FSM state encoding for the
// PHY length divider and the reusable N_DBPS lookup.
package phy_len_div_calc_pkg;

    localparam int unsigned DBPS_W       = 11;
    localparam int unsigned SERVICE_BITS = 16;
    localparam int unsigned TAIL_BITS    = 6;
    localparam int unsigned HT_MCS_UEQM  = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    // A zero return marks a code that is not a legal non-HT rate.
    function automatic logic [DBPS_W-1:0] nonht_dbps(input logic [3:0] code);
        case (code)
            4'b1011: return DBPS_W'(24);
            4'b1111: return DBPS_W'(36);
            4'b1010: return DBPS_W'(48);
            4'b1110: return DBPS_W'(72);
            4'b1001: return DBPS_W'(96);
            4'b1101: return DBPS_W'(144);
            4'b1000: return DBPS_W'(192);
            4'b1100: return DBPS_W'(216);
            default: return '0;
        endcase
    endfunction

    function automatic logic [DBPS_W-1:0] ht_base_dbps(input logic [2:0] idx);
        case (idx)
            3'd0:    return DBPS_W'(26);
            3'd1:    return DBPS_W'(52);
            3'd2:    return DBPS_W'(78);
            3'd3:    return DBPS_W'(104);
            3'd4:    return DBPS_W'(156);
            3'd5:    return DBPS_W'(208);
            3'd6:    return DBPS_W'(234);
            default: return DBPS_W'(260);
        endcase
    endfunction

endpackage

// File: rtl/phy_len_div_calc_ndbps_lookup.sv
// Combinational N_DBPS lookup for non-HT rate codes and HT MCS (equal
// modulation, up to MAX_NSS streams); flags unsupported rates.
module ndbps_lookup
    import phy_len_div_calc_pkg::*;
#(
    parameter int unsigned MAX_NSS = 2
) (
    input  logic              ht_i,
    input  logic [6:0]        rate_i,
    output logic [DBPS_W-1:0] n_dbps_o,
    output logic              rate_err_o
);

    logic [2:0] nss;

    always_comb begin
        n_dbps_o   = '0;
        rate_err_o = 1'b0;
        nss        = {1'b0, rate_i[4:3]} + 3'd1;
        if (ht_i) begin
            if ((32'(rate_i) >= HT_MCS_UEQM) || (32'(rate_i) >= 8 * MAX_NSS)) begin
                rate_err_o = 1'b1;
            end else begin
                n_dbps_o = ht_base_dbps(rate_i[2:0]) * DBPS_W'(nss);
            end
        end else begin
            n_dbps_o   = nonht_dbps(rate_i[3:0]);
            rate_err_o = (n_dbps_o == '0);
        end
    end

endmodule

// File: rtl/phy_len_div_calc.sv
// PHY length calculator: N_DBPS lookup followed by a fixed-latency restoring
// divider. Defining PHY_LEN_PAD_EN adds the n_pad_bit output.
module phy_len_div_calc
    import phy_len_div_calc_pkg::*;
#(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned MAX_NSS = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic              ht,
    input  logic [6:0]        rate,
    input  logic [LEN_W-1:0]  psdu_len,
    output logic [LEN_W-1:0]  n_ofdm_sym,
    output logic [DBPS_W-1:0] n_bit_in_last_sym,
    output logic [DBPS_W-1:0] n_dbps,
    output logic              busy,
    output logic              phy_len_valid,
    output logic              rate_err
`ifdef PHY_LEN_PAD_EN
    ,
    output logic [DBPS_W-1:0] n_pad_bit
`endif
);

    localparam int unsigned NUM_W = LEN_W + 4;
    localparam int unsigned SYM_W = LEN_W;
    localparam int unsigned CNT_W = $clog2(NUM_W);

    state_t             state_q;
    logic               ht_q;
    logic [6:0]         rate_q;
    logic [LEN_W-1:0]   len_q;
    logic [NUM_W-1:0]   num_q;
    logic [SYM_W-1:0]   quo_q;
    logic [DBPS_W-1:0]  dbps_q;
    logic [DBPS_W-1:0]  rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SYM_W-1:0]   sym_q;
    logic [DBPS_W-1:0]  last_q;
    logic [DBPS_W-1:0]  ndbps_q;
    logic               busy_q;
    logic               valid_q;
    logic               err_q;
`ifdef PHY_LEN_PAD_EN
    logic [DBPS_W-1:0]  pad_q;
`endif

    logic [DBPS_W-1:0]  lut_dbps;
    logic               lut_err;
    logic [NUM_W-1:0]   num_d;
    logic [DBPS_W:0]    rem_shift;
    logic [DBPS_W:0]    rem_diff;
    logic               rem_ge;
    logic [DBPS_W-1:0]  rem_d;

    ndbps_lookup #(.MAX_NSS(MAX_NSS)) u_ndbps_lookup (
        .ht_i       (ht_q),
        .rate_i     (rate_q),
        .n_dbps_o   (lut_dbps),
        .rate_err_o (lut_err)
    );

    always_comb begin
        num_d     = {1'b0, len_q, 3'b000} + NUM_W'(SERVICE_BITS + TAIL_BITS);
        rem_shift = {rem_q, num_q[NUM_W-1]};
        rem_diff  = rem_shift - {1'b0, dbps_q};
        rem_ge    = (rem_shift >= {1'b0, dbps_q});
        rem_d     = rem_ge ? rem_diff[DBPS_W-1:0] : rem_shift[DBPS_W-1:0];
    end

    // Quotient is kept SYM_W wide: with N_DBPS >= 24 its upper NUM_W-SYM_W
    // bits are always zero, so shifting them out loses nothing.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ht_q    <= 1'b0;
            rate_q  <= '0;
            len_q   <= '0;
            num_q   <= '0;
            quo_q   <= '0;
            dbps_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sym_q   <= SYM_W'(1);
            last_q  <= DBPS_W'(130);
            ndbps_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef PHY_LEN_PAD_EN
            pad_q   <= '0;
`endif
        end else if (enable) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        ht_q    <= ht;
                        rate_q  <= rate;
                        len_q   <= psdu_len;
                        busy_q  <= 1'b1;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    dbps_q <= lut_dbps;
                    num_q  <= num_d;
                    if (lut_err) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        quo_q   <= '0;
                        rem_q   <= '0;
                        cnt_q   <= CNT_W'(NUM_W - 1);
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= {quo_q[SYM_W-2:0], rem_ge};
                    num_q <= {num_q[NUM_W-2:0], 1'b0};
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_FIX: begin
                    ndbps_q <= dbps_q;
                    if (rem_q == '0) begin
                        sym_q  <= quo_q;
                        last_q <= dbps_q;
`ifdef PHY_LEN_PAD_EN
                        pad_q  <= '0;
`endif
                    end else begin
                        sym_q  <= quo_q + SYM_W'(1);
                        last_q <= rem_q;
`ifdef PHY_LEN_PAD_EN
                        pad_q  <= dbps_q - rem_q;
`endif
                    end
                    valid_q <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign n_ofdm_sym        = sym_q;
    assign n_bit_in_last_sym = last_q;
    assign n_dbps            = ndbps_q;
    assign busy              = busy_q;
    assign phy_len_valid     = valid_q;
    assign rate_err          = err_q;
`ifdef PHY_LEN_PAD_EN
    assign n_pad_bit         = pad_q;
`endif

endmodule

// File: tb/tb_phy_len_div_calc.sv
// Self-checking bench for phy_len_div_calc: scoreboard of expected results,
// directed vectors, rate errors, reset/enable/start-while-busy behaviour.
module tb_phy_len_div_calc;

    localparam int unsigned LEN_W   = 16;
    localparam int unsigned MAX_NSS = 2;
    localparam int unsigned LAT     = LEN_W + 4 + 3;

    typedef struct {
        logic [15:0] sym;
        logic [10:0] last;
        logic [10:0] dbps;
        logic [10:0] pad;
    } exp_t;

    typedef struct {
        bit          h;
        int unsigned r;
        int unsigned len;
        int unsigned sym;
        int unsigned last;
        int unsigned dbps;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        start;
    logic        ht;
    logic [6:0]  rate;
    logic [15:0] psdu_len;
    logic [15:0] n_ofdm_sym;
    logic [10:0] n_bit_in_last_sym;
    logic [10:0] n_dbps;
    logic        busy;
    logic        phy_len_valid;
    logic        rate_err;
`ifdef PHY_LEN_PAD_EN
    logic [10:0] n_pad_bit;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;
    exp_t        sb[$];
    exp_t        last_good;

    always #5 clock = ~clock;

    phy_len_div_calc #(.LEN_W(LEN_W), .MAX_NSS(MAX_NSS)) dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .start             (start),
        .ht                (ht),
        .rate              (rate),
        .psdu_len          (psdu_len),
        .n_ofdm_sym        (n_ofdm_sym),
        .n_bit_in_last_sym (n_bit_in_last_sym),
        .n_dbps            (n_dbps),
        .busy              (busy),
        .phy_len_valid     (phy_len_valid),
        .rate_err          (rate_err)
`ifdef PHY_LEN_PAD_EN
        ,
        .n_pad_bit         (n_pad_bit)
`endif
    );

    // Reference N_DBPS; 0 means the rate is unsupported.
    function automatic int unsigned model_dbps(input bit h, input int unsigned r);
        int unsigned base[8] = '{26, 52, 78, 104, 156, 208, 234, 260};
        if (h) begin
            if (r >= 32 || r >= 8 * MAX_NSS) return 0;
            return base[r % 8] * (r / 8 + 1);
        end
        case (r % 16)
            11: return 24;
            15: return 36;
            10: return 48;
            14: return 72;
            9:  return 96;
            13: return 144;
            8:  return 192;
            12: return 216;
            default: return 0;
        endcase
    endfunction

    // Drives a one-cycle start at the current negedge; returns at the cycle-1 negedge.
    task automatic issue(input bit h, input int unsigned r, input int unsigned len);
        start    = 1'b1;
        ht       = h;
        rate     = 7'(r);
        psdu_len = 16'(len);
        @(negedge clock);
        start    = 1'b0;
    endtask

    task automatic push_model(input bit h, input int unsigned r, input int unsigned len);
        exp_t        e;
        int unsigned d, num, s;
        d = model_dbps(h, r);
        if (d != 0) begin
            num    = 22 + 8 * len;
            s      = (num + d - 1) / d;
            e.sym  = 16'(s);
            e.last = 11'(num - (s - 1) * d);
            e.dbps = 11'(d);
            e.pad  = 11'(d - (num - (s - 1) * d));
            sb.push_back(e);
        end
    endtask

    task automatic wait_valid(output int unsigned cyc, output bit seen);
        cyc = 1;
        while (!phy_len_valid && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        seen = phy_len_valid;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        enable = 1'b1;
        start  = 1'b0;
        ht     = 1'b0;
        rate   = '0;
        psdu_len = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({n_ofdm_sym, n_bit_in_last_sym, n_dbps} !== {16'd1, 11'd130, 11'd0}) begin
            failures++;
            $display("FAIL reset_values: got sym=%0d last=%0d dbps=%0d, expected 1/130/0",
                     n_ofdm_sym, n_bit_in_last_sym, n_dbps);
        end
        checks++;
        if ({busy, phy_len_valid, rate_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got busy/valid/err=%b, expected 000",
                     {busy, phy_len_valid, rate_err});
        end
`ifdef PHY_LEN_PAD_EN
        checks++;
        if (n_pad_bit !== 11'd0) begin
            failures++;
            $display("FAIL reset_pad: got %0d expected 0", n_pad_bit);
        end
`endif
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_directed();
        vec_t        v[5];
        exp_t        e;
        int unsigned cyc;
        bit          seen;
        v[0] = '{0, 11, 0,    1,  22,  24};
        v[1] = '{0, 12, 100,  4,  174, 216};
        v[2] = '{1, 0,  7,    3,  26,  26};
        v[3] = '{1, 7,  1500, 47, 62,  260};
        v[4] = '{1, 15, 1500, 24, 62,  520};
        foreach (v[i]) begin
            e.sym  = 16'(v[i].sym);
            e.last = 11'(v[i].last);
            e.dbps = 11'(v[i].dbps);
            e.pad  = 11'(v[i].dbps - v[i].last);
            sb.push_back(e);
            issue(v[i].h, v[i].r, v[i].len);
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL directed_busy_c1[%0d]: got %b expected 1", i, busy);
            end
            wait_valid(cyc, seen);
            checks++;
            if (!seen || cyc != LAT) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got seen=%0d cycle=%0d expected cycle %0d",
                         i, seen, cyc, LAT);
            end
            e = sb.pop_front();
            last_good = e;
            checks++;
            if ({n_ofdm_sym, n_bit_in_last_sym, n_dbps} !== {e.sym, e.last, e.dbps}) begin
                failures++;
                $display("FAIL directed_result[%0d]: got sym=%0d last=%0d dbps=%0d expected %0d/%0d/%0d",
                         i, n_ofdm_sym, n_bit_in_last_sym, n_dbps, e.sym, e.last, e.dbps);
            end
`ifdef PHY_LEN_PAD_EN
            checks++;
            if (n_pad_bit !== e.pad) begin
                failures++;
                $display("FAIL directed_pad[%0d]: got %0d expected %0d", i, n_pad_bit, e.pad);
            end
`endif
            @(negedge clock);
            checks++;
            if ({busy, phy_len_valid} !== 2'b00) begin
                failures++;
                $display("FAIL directed_done_drop[%0d]: got busy/valid=%b expected 00",
                         i, {busy, phy_len_valid});
            end
        end
    endtask

    task automatic test_rate_err();
        bit          hs[3] = '{1, 0, 1};
        int unsigned rs[3] = '{16, 7, 33};
        bit          got_valid;
        foreach (hs[i]) begin
            push_model(hs[i], rs[i], 200);
            issue(hs[i], rs[i], 200);
            checks++;
            if (rate_err !== 1'b0) begin
                failures++;
                $display("FAIL rate_err_early[%0d]: got %b expected 0 at cycle 1", i, rate_err);
            end
            @(negedge clock);
            checks++;
            if ({rate_err, busy} !== 2'b10) begin
                failures++;
                $display("FAIL rate_err_c2[%0d]: got err/busy=%b expected 10", i, {rate_err, busy});
            end
            got_valid = 1'b0;
            repeat (30) begin
                @(negedge clock);
                if (phy_len_valid) got_valid = 1'b1;
            end
            checks++;
            if (got_valid !== 1'b0 || sb.size() != 0) begin
                failures++;
                $display("FAIL rate_err_no_valid[%0d]: got valid=%0d queued=%0d expected 0/0",
                         i, got_valid, sb.size());
            end
            checks++;
            if ({n_ofdm_sym, n_bit_in_last_sym, n_dbps} !== {last_good.sym, last_good.last, last_good.dbps}) begin
                failures++;
                $display("FAIL rate_err_hold[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i,
                         n_ofdm_sym, n_bit_in_last_sym, n_dbps, last_good.sym, last_good.last, last_good.dbps);
            end
            sb.delete();
        end
    endtask

    task automatic test_busy_start();
        exp_t        e;
        int unsigned cyc;
        bit          seen;
        bit          got_valid;
        push_model(0, 9, 333);
        issue(0, 9, 333);
        repeat (4) @(negedge clock);
        issue(1, 3, 5);
        wait_valid(cyc, seen);
        checks++;
        if (!seen || cyc != LAT - 5) begin
            failures++;
            $display("FAIL busy_start_latency: got seen=%0d cycle=%0d expected %0d", seen, cyc, LAT - 5);
        end
        e = sb.pop_front();
        last_good = e;
        checks++;
        if ({n_ofdm_sym, n_bit_in_last_sym, n_dbps} !== {e.sym, e.last, e.dbps}) begin
            failures++;
            $display("FAIL busy_start_result: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     n_ofdm_sym, n_bit_in_last_sym, n_dbps, e.sym, e.last, e.dbps);
        end
        // start coincides with DONE and must be dropped
        issue(1, 1, 50);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_in_done_busy: got %b expected 0", busy);
        end
        got_valid = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (phy_len_valid || busy) got_valid = 1'b1;
        end
        checks++;
        if (got_valid !== 1'b0) begin
            failures++;
            $display("FAIL busy_start_ignored: got activity=%0d expected 0", got_valid);
        end
    endtask

    task automatic test_enable_stall();
        exp_t        e;
        int unsigned cyc;
        push_model(1, 12, 777);
        issue(1, 12, 777);
        cyc = 1;
        while (!phy_len_valid && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (cyc == 8)  enable = 1'b0;
            if (cyc == 9)  start  = 1'b1;
            if (cyc == 10) start  = 1'b0;
            if (cyc == 13) enable = 1'b1;
        end
        checks++;
        if (!phy_len_valid || cyc != LAT + 5) begin
            failures++;
            $display("FAIL enable_stall_latency: got valid=%0d cycle=%0d expected %0d",
                     phy_len_valid, cyc, LAT + 5);
        end
        e = sb.pop_front();
        last_good = e;
        checks++;
        if ({n_ofdm_sym, n_bit_in_last_sym, n_dbps} !== {e.sym, e.last, e.dbps}) begin
            failures++;
            $display("FAIL enable_stall_result: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     n_ofdm_sym, n_bit_in_last_sym, n_dbps, e.sym, e.last, e.dbps);
        end
        @(negedge clock);
    endtask

    task automatic test_mid_reset();
        bit got_valid;
        push_model(0, 13, 1234);
        issue(0, 13, 1234);
        repeat (9) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        checks++;
        if ({n_ofdm_sym, n_bit_in_last_sym, n_dbps, busy} !== {16'd1, 11'd130, 11'd0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset_values: got %0d/%0d/%0d busy=%b expected 1/130/0 busy=0",
                     n_ofdm_sym, n_bit_in_last_sym, n_dbps, busy);
        end
        got_valid = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (phy_len_valid) got_valid = 1'b1;
        end
        checks++;
        if (got_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_no_valid: got %0d expected 0", got_valid);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned codes[8] = '{11, 15, 10, 14, 9, 13, 8, 12};
        exp_t        e;
        int unsigned cyc, r, len;
        bit          h, seen;
        for (int n = 0; n < 10; n++) begin
            h   = 1'($urandom_range(0, 1));
            r   = h ? $urandom_range(0, 15) : codes[$urandom_range(0, 7)];
            len = (n == 0) ? 65535 : $urandom_range(0, 65535);
            push_model(h, r, len);
            issue(h, r, len);
            wait_valid(cyc, seen);
            checks++;
            if (!seen || cyc != LAT) begin
                failures++;
                $display("FAIL b2b_latency[%0d]: got seen=%0d cycle=%0d expected %0d", n, seen, cyc, LAT);
            end
            e = sb.pop_front();
            checks++;
            if ({n_ofdm_sym, n_bit_in_last_sym, n_dbps} !== {e.sym, e.last, e.dbps}) begin
                failures++;
                $display("FAIL b2b_result[%0d]: ht=%0d rate=%0d len=%0d got %0d/%0d/%0d expected %0d/%0d/%0d",
                         n, h, r, len, n_ofdm_sym, n_bit_in_last_sym, n_dbps, e.sym, e.last, e.dbps);
            end
`ifdef PHY_LEN_PAD_EN
            checks++;
            if (n_pad_bit !== e.pad) begin
                failures++;
                $display("FAIL b2b_pad[%0d]: got %0d expected %0d", n, n_pad_bit, e.pad);
            end
`endif
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_rate_err();
        test_busy_start();
        test_enable_stall();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
